piso_serializer: RTL and testbench

Parallel-in, serial-out shift register with a valid/ready load handshake and a stallable serial side. It is the transmit counterpart to the team's parallel-capture registers. It accepts a WIDTH-bit word from a parallel producer and emits it one bit per enabled clock, with frame markers for the downstream serial consumer. Back-to-back words stream with no idle gap.

---
 rtl/piso_serializer.sv | 99 +++++++++
 tb/tb_piso_serializer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register: takes a WIDTH-bit word over a
// valid/ready load port and emits it one bit per enabled clock with frame markers.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] par_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit, accept, out_bit;

  // Handshake: a word transfers on any rising edge where load_valid and
  // load_ready are both high. load_ready is combinational so a new word can be
  // taken in the same cycle the last bit of the current frame is consumed;
  // the producer must hold load_valid and par_in until that transfer.
  assign last_bit   = (cnt_q == CNT_LAST);
  assign load_ready = !rst && ((state_q == IDLE) ||
                               ((state_q == SHIFT) && last_bit && shift_en));
  assign accept     = load_valid && load_ready;

  if (MSB_FIRST) begin : g_msb_first
    assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
    assign out_bit      = sreg_q[WIDTH-1];
  end else begin : g_lsb_first
    assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
    assign out_bit      = sreg_q[0];
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sreg_d  = par_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // With shift_en low everything holds, so a stall works on any bit.
        if (shift_en) begin
          if (!last_bit) begin
            sreg_d = sreg_shifted;
            cnt_d  = cnt_q + 1'b1;
          end else if (accept) begin
            sreg_d = par_in;
            cnt_d  = '0;
          end else begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_valid   = (state_q == SHIFT);
  assign busy        = ser_valid;
  assign ser_out     = ser_valid && out_bit;
  assign frame_start = ser_valid && (cnt_q == '0);
  assign frame_end   = ser_valid && last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share the
// same inputs; expected serial bits are queued on accept and popped on consume.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] par_in = '0;
  logic       load_valid = 1'b0;
  logic       shift_en = 1'b0;

  logic ready_m, ser_out_m, valid_m, fs_m, fe_m, busy_m;
  logic ready_l, ser_out_l, valid_l, fs_l, fe_l, busy_l;

  wire [4:0] flags_m = {valid_m, busy_m, fs_m, fe_m, ready_m};
  wire [4:0] flags_l = {valid_l, busy_l, fs_l, fe_l, ready_l};

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];
  logic       exp_bit;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid),
    .load_ready(ready_m), .shift_en(shift_en), .ser_out(ser_out_m),
    .ser_valid(valid_m), .frame_start(fs_m), .frame_end(fe_m), .busy(busy_m)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .par_in(par_in), .load_valid(load_valid),
    .load_ready(ready_l), .shift_en(shift_en), .ser_out(ser_out_l),
    .ser_valid(valid_l), .frame_start(fs_l), .frame_end(fe_l), .busy(busy_l)
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic [3:0] d, input logic lv, input logic se);
    @(negedge clk);
    rst        = r;
    par_in     = d;
    load_valid = lv;
    shift_en   = se;
    #1;
  endtask

  task automatic push_word(input logic [3:0] w, input logic msb);
    for (int k = 0; k < 4; k++) exp_q.push_back(msb ? w[3-k] : w[k]);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'hF, 1'b1, 1'b1);
      n_cmp++;
      if ({flags_m, ser_out_m} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_m cyc %0d: got %b, want 000000", i, {flags_m, ser_out_m});
      end
      n_cmp++;
      if ({flags_l, ser_out_l} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_l cyc %0d: got %b, want 000000", i, {flags_l, ser_out_l});
      end
    end
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    n_cmp++;
    if ({flags_m, ser_out_m} !== 6'b000010) begin
      n_err++;
      $display("FAIL reset_release: got %b, want 000010", {flags_m, ser_out_m});
    end
    exp_q.delete();
  endtask

  // Table rows: {din[3:0], load_valid, shift_en, valid, busy, fs, fe, ready}
  task automatic test_single_frame();
    logic [10:0] tbl [6] = '{
      {4'hB, 1'b1, 1'b1, 5'b00001}, {4'h0, 1'b0, 1'b1, 5'b11100},
      {4'h0, 1'b0, 1'b1, 5'b11000}, {4'h0, 1'b0, 1'b1, 5'b11000},
      {4'h0, 1'b0, 1'b1, 5'b11011}, {4'h0, 1'b0, 1'b1, 5'b00001}};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, tbl[i][10:7], tbl[i][6], tbl[i][5]);
      n_cmp++;
      if (flags_m !== tbl[i][4:0]) begin
        n_err++;
        $display("FAIL single_flags cyc %0d: got %b, want %b", i, flags_m, tbl[i][4:0]);
      end
      exp_bit = (tbl[i][4] && exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (ser_out_m !== exp_bit) begin
        n_err++;
        $display("FAIL single_ser cyc %0d: got %b, want %b", i, ser_out_m, exp_bit);
      end
      if (tbl[i][4] && tbl[i][5] && exp_q.size() > 0) void'(exp_q.pop_front());
      if (tbl[i][6] && tbl[i][0]) push_word(tbl[i][10:7], 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] tbl [10] = '{
      {4'hA, 1'b1, 1'b1, 5'b00001}, {4'h5, 1'b1, 1'b1, 5'b11100},
      {4'h5, 1'b1, 1'b1, 5'b11000}, {4'h5, 1'b1, 1'b1, 5'b11000},
      {4'h5, 1'b1, 1'b1, 5'b11011}, {4'h0, 1'b0, 1'b1, 5'b11100},
      {4'h0, 1'b0, 1'b1, 5'b11000}, {4'h0, 1'b0, 1'b1, 5'b11000},
      {4'h0, 1'b0, 1'b1, 5'b11011}, {4'h0, 1'b0, 1'b1, 5'b00001}};
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, tbl[i][10:7], tbl[i][6], tbl[i][5]);
      n_cmp++;
      if (flags_m !== tbl[i][4:0]) begin
        n_err++;
        $display("FAIL b2b_flags cyc %0d: got %b, want %b", i, flags_m, tbl[i][4:0]);
      end
      exp_bit = (tbl[i][4] && exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (ser_out_m !== exp_bit) begin
        n_err++;
        $display("FAIL b2b_ser cyc %0d: got %b, want %b", i, ser_out_m, exp_bit);
      end
      if (tbl[i][4] && tbl[i][5] && exp_q.size() > 0) void'(exp_q.pop_front());
      if (tbl[i][6] && tbl[i][0]) push_word(tbl[i][10:7], 1'b1);
    end
  endtask

  // Second frame stalls on its first and last bits and offers a word while not ready.
  task automatic test_stall();
    logic [10:0] tbl [15] = '{
      {4'hC, 1'b1, 1'b1, 5'b00001}, {4'h0, 1'b0, 1'b1, 5'b11100},
      {4'h0, 1'b0, 1'b0, 5'b11000}, {4'h0, 1'b0, 1'b0, 5'b11000},
      {4'h0, 1'b0, 1'b1, 5'b11000}, {4'h0, 1'b0, 1'b1, 5'b11000},
      {4'h0, 1'b0, 1'b1, 5'b11011}, {4'h9, 1'b1, 1'b1, 5'b00001},
      {4'h0, 1'b0, 1'b0, 5'b11100}, {4'h0, 1'b0, 1'b1, 5'b11100},
      {4'h0, 1'b0, 1'b1, 5'b11000}, {4'h0, 1'b0, 1'b1, 5'b11000},
      {4'hF, 1'b1, 1'b0, 5'b11010}, {4'h0, 1'b0, 1'b1, 5'b11011},
      {4'h0, 1'b0, 1'b1, 5'b00001}};
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, tbl[i][10:7], tbl[i][6], tbl[i][5]);
      n_cmp++;
      if (flags_m !== tbl[i][4:0]) begin
        n_err++;
        $display("FAIL stall_flags cyc %0d: got %b, want %b", i, flags_m, tbl[i][4:0]);
      end
      exp_bit = (tbl[i][4] && exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (ser_out_m !== exp_bit) begin
        n_err++;
        $display("FAIL stall_ser cyc %0d: got %b, want %b", i, ser_out_m, exp_bit);
      end
      if (tbl[i][4] && tbl[i][5] && exp_q.size() > 0) void'(exp_q.pop_front());
      if (tbl[i][6] && tbl[i][0]) push_word(tbl[i][10:7], 1'b1);
    end
  endtask

  task automatic test_lsb_first();
    logic [10:0] tbl [6] = '{
      {4'hB, 1'b1, 1'b1, 5'b00001}, {4'h0, 1'b0, 1'b1, 5'b11100},
      {4'h0, 1'b0, 1'b1, 5'b11000}, {4'h0, 1'b0, 1'b1, 5'b11000},
      {4'h0, 1'b0, 1'b1, 5'b11011}, {4'h0, 1'b0, 1'b1, 5'b00001}};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, tbl[i][10:7], tbl[i][6], tbl[i][5]);
      n_cmp++;
      if (flags_l !== tbl[i][4:0]) begin
        n_err++;
        $display("FAIL lsb_flags cyc %0d: got %b, want %b", i, flags_l, tbl[i][4:0]);
      end
      exp_bit = (tbl[i][4] && exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (ser_out_l !== exp_bit) begin
        n_err++;
        $display("FAIL lsb_ser cyc %0d: got %b, want %b", i, ser_out_l, exp_bit);
      end
      if (tbl[i][4] && tbl[i][5] && exp_q.size() > 0) void'(exp_q.pop_front());
      if (tbl[i][6] && tbl[i][0]) push_word(tbl[i][10:7], 1'b0);
    end
  endtask

  task automatic test_load_while_busy();
    logic [10:0] tbl [7] = '{
      {4'hF, 1'b1, 1'b1, 5'b00001}, {4'h0, 1'b0, 1'b1, 5'b11100},
      {4'h0, 1'b1, 1'b1, 5'b11000}, {4'h0, 1'b0, 1'b1, 5'b11000},
      {4'h0, 1'b0, 1'b1, 5'b11011}, {4'h0, 1'b0, 1'b1, 5'b00001},
      {4'h0, 1'b0, 1'b1, 5'b00001}};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, tbl[i][10:7], tbl[i][6], tbl[i][5]);
      n_cmp++;
      if (flags_m !== tbl[i][4:0]) begin
        n_err++;
        $display("FAIL busy_load_flags cyc %0d: got %b, want %b", i, flags_m, tbl[i][4:0]);
      end
      exp_bit = (tbl[i][4] && exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (ser_out_m !== exp_bit) begin
        n_err++;
        $display("FAIL busy_load_ser cyc %0d: got %b, want %b", i, ser_out_m, exp_bit);
      end
      if (tbl[i][4] && tbl[i][5] && exp_q.size() > 0) void'(exp_q.pop_front());
      if (tbl[i][6] && tbl[i][0]) push_word(tbl[i][10:7], 1'b1);
    end
  endtask

  // Rows gain a leading rst bit: {rst, din, load_valid, shift_en, flags}
  task automatic test_reset_mid_frame();
    logic [11:0] tbl [10] = '{
      {1'b0, 4'hA, 1'b1, 1'b1, 5'b00001}, {1'b0, 4'h0, 1'b0, 1'b1, 5'b11100},
      {1'b1, 4'h0, 1'b0, 1'b1, 5'b11000}, {1'b1, 4'h0, 1'b0, 1'b1, 5'b00000},
      {1'b0, 4'h6, 1'b1, 1'b1, 5'b00001}, {1'b0, 4'h0, 1'b0, 1'b1, 5'b11100},
      {1'b0, 4'h0, 1'b0, 1'b1, 5'b11000}, {1'b0, 4'h0, 1'b0, 1'b1, 5'b11000},
      {1'b0, 4'h0, 1'b0, 1'b1, 5'b11011}, {1'b0, 4'h0, 1'b0, 1'b1, 5'b00001}};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i][11], tbl[i][10:7], tbl[i][6], tbl[i][5]);
      n_cmp++;
      if (flags_m !== tbl[i][4:0]) begin
        n_err++;
        $display("FAIL rst_mid_flags cyc %0d: got %b, want %b", i, flags_m, tbl[i][4:0]);
      end
      exp_bit = (tbl[i][4] && exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (ser_out_m !== exp_bit) begin
        n_err++;
        $display("FAIL rst_mid_ser cyc %0d: got %b, want %b", i, ser_out_m, exp_bit);
      end
      if (tbl[i][4] && tbl[i][5] && exp_q.size() > 0) void'(exp_q.pop_front());
      if (tbl[i][11]) exp_q.delete();
      if (tbl[i][6] && tbl[i][0]) push_word(tbl[i][10:7], 1'b1);
    end
  endtask

  task automatic test_random_stream();
    logic       m_busy = 1'b0;
    int         m_cnt = 0;
    logic       lv = 1'b0;
    logic       se, exp_ready, acc;
    logic [3:0] word = '0;
    logic [4:0] exp_flags;
    for (int i = 0; i < 320; i++) begin
      se = (i >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!lv && i < 300 && $urandom_range(0, 2) != 0) begin
        lv   = 1'b1;
        word = 4'($urandom_range(0, 15));
      end
      exp_ready = !m_busy || (m_cnt == 3 && se);
      exp_flags = {m_busy, m_busy, m_busy && m_cnt == 0, m_busy && m_cnt == 3, exp_ready};
      drive(1'b0, word, lv, se);
      n_cmp++;
      if (flags_m !== exp_flags) begin
        n_err++;
        $display("FAIL random_flags cyc %0d: got %b, want %b", i, flags_m, exp_flags);
      end
      exp_bit = (m_busy && exp_q.size() > 0) ? exp_q[0] : 1'b0;
      n_cmp++;
      if (ser_out_m !== exp_bit) begin
        n_err++;
        $display("FAIL random_ser cyc %0d: got %b, want %b", i, ser_out_m, exp_bit);
      end
      if (m_busy && se && exp_q.size() > 0) void'(exp_q.pop_front());
      acc = lv && exp_ready;
      if (m_busy) begin
        if (se) begin
          if (m_cnt == 3) begin
            m_busy = acc;
            m_cnt  = 0;
          end else begin
            m_cnt++;
          end
        end
      end else if (acc) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
      if (acc) begin
        push_word(word, 1'b1);
        lv = 1'b0;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: got %0d bits left, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_lsb_first();
    test_load_while_busy();
    test_reset_mid_frame();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
